// File: rtl/alu_mdu.sv
// Stage-E execute unit: combinational ALU plus a fixed-latency multiply/divide unit
// that writes HI/LO when its busy window closes.
module alu_mdu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] ext,
  input  logic [3:0]       alu_op,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_ovf,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned SW   = $clog2(WIDTH);
  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_ORI, OP_MEM, OP_LUI, OP_SLL, OP_ADDI, OP_AND,
    OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SRL, OP_SRA, OP_ZERO
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_RSVD
  } md_op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  // ---------------- ALU ----------------
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sum_rt, diff_rt, sum_ext;

  assign shamt   = ext[SW-1:0];
  assign sum_rt  = rs + rt;
  assign diff_rt = rs - rt;
  assign sum_ext = rs + ext;

  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (alu_op_e'(alu_op))
      OP_ADD: begin
        alu_out = sum_rt;
        alu_ovf = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum_rt[WIDTH-1] != rs[WIDTH-1]);
      end
      OP_SUB: begin
        alu_out = diff_rt;
        alu_ovf = (rs[WIDTH-1] != rt[WIDTH-1]) && (diff_rt[WIDTH-1] != rs[WIDTH-1]);
      end
      OP_ORI:  alu_out = rs | ext;
      OP_MEM:  alu_out = sum_ext;
      OP_LUI:  alu_out = ext << (WIDTH / 2);
      OP_SLL:  alu_out = rt << shamt;
      OP_ADDI: begin
        alu_out = sum_ext;
        alu_ovf = (rs[WIDTH-1] == ext[WIDTH-1]) && (sum_ext[WIDTH-1] != rs[WIDTH-1]);
      end
      OP_AND:  alu_out = rs & rt;
      OP_OR:   alu_out = rs | rt;
      OP_XOR:  alu_out = rs ^ rt;
      OP_NOR:  alu_out = ~(rs | rt);
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (rs < rt)};
      OP_SRL:  alu_out = rt >> shamt;
      OP_SRA:  alu_out = $signed(rt) >>> shamt;
      default: alu_out = '0;
    endcase
  end

  // ---------------- MDU ----------------
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0]      prod_s, prod_u;
  logic [WIDTH-1:0]        div_b, quo_u, rem_u;
  logic signed [WIDTH-1:0] quo_s, rem_s;
  logic                    div_zero, min_neg1;

  // Signed product taken as the low 2W bits of the sign-extended operands' product.
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Divisor is forced non-zero so the dividers never see /0; the result is discarded then.
  assign div_zero = (b_q == '0);
  assign min_neg1 = (a_q == SMIN) && (b_q == '1);
  assign div_b    = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
  assign quo_u    = a_q / div_b;
  assign rem_u    = a_q % div_b;
  assign quo_s    = $signed(a_q) / $signed(div_b);
  assign rem_s    = $signed(a_q) % $signed(div_b);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          case (md_op_e'(md_op))
            MD_MULT, MD_MULTU: begin
              a_d = rs; b_d = rt; op_d = md_op_e'(md_op);
              cnt_d = CW'(MULT_CYCLES); state_d = S_RUN;
            end
            MD_DIV, MD_DIVU: begin
              a_d = rs; b_d = rt; op_d = md_op_e'(md_op);
              cnt_d = CW'(DIV_CYCLES); state_d = S_RUN;
            end
            MD_MTHI: hi_d = rs;
            MD_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          case (op_q)
            MD_MULT:  {hi_d, lo_d} = prod_s;
            MD_MULTU: {hi_d, lo_d} = prod_u;
            MD_DIV: begin
              if (min_neg1) begin
                lo_d = SMIN; hi_d = '0;
              end else if (!div_zero) begin
                lo_d = quo_s; hi_d = rem_s;
              end
            end
            MD_DIVU: begin
              if (!div_zero) begin
                lo_d = quo_u; hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_busy = (state_q == S_RUN);
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu: ALU op table, MDU latency, HI/LO results,
// ignored starts while busy, and reset during an operation.
module tb_alu_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] rs, rt, ext;
  logic [3:0]  alu_op;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] alu_out, hi_out, lo_out;
  logic        alu_ovf, md_busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .ext(ext),
    .alu_op(alu_op), .md_op(md_op), .md_start(md_start),
    .alu_out(alu_out), .alu_ovf(alu_ovf), .md_busy(md_busy),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses md_start for one cycle; afterwards the bench sits in busy cycle 1.
  task automatic md_go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; rs = a; rt = b; md_start = 1'b1;
    step();
    md_start = 1'b0; md_op = 3'd0; rs = 32'hDEADBEEF; rt = 32'hDEADBEEF;
  endtask

  task automatic wait_idle(input string tag, input int unsigned exp_cycles);
    int unsigned n = 0;
    while (md_busy && n < 64) begin
      n++;
      step();
    end
    check(tag, 64'(n), 64'(exp_cycles));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, e, res;
    logic        ovf;
  } alu_vec_t;

  alu_vec_t vecs[$];

  initial begin
    reset = 1'b1; rs = '0; rt = '0; ext = '0; alu_op = '0; md_op = '0; md_start = 1'b0;
    step(); step();
    check("rst_busy", 64'(md_busy), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b0;

    vecs = '{
      '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h80000000, 1'b1},
      '{4'd1,  32'h80000000, 32'h00000001, 32'h0,        32'h7FFFFFFF, 1'b1},
      '{4'd1,  32'h00000005, 32'h00000007, 32'h0,        32'hFFFFFFFE, 1'b0},
      '{4'd2,  32'hF0F00000, 32'h0,        32'h0000FFFF, 32'hF0F0FFFF, 1'b0},
      '{4'd3,  32'h00001000, 32'h0,        32'hFFFFFFFC, 32'h00000FFC, 1'b0},
      '{4'd4,  32'h0,        32'h0,        32'h00001234, 32'h12340000, 1'b0},
      '{4'd5,  32'h0,        32'h00000001, 32'h0000003F, 32'h80000000, 1'b0},
      '{4'd6,  32'h80000000, 32'h0,        32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1},
      '{4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, 1'b0},
      '{4'd7,  32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h00000001, 1'b0},
      '{4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hFFF0FFF0, 1'b0},
      '{4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0FF00FF0, 1'b0},
      '{4'd10, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        32'h00000000, 1'b0},
      '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000001, 1'b0},
      '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000000, 1'b0},
      '{4'd13, 32'h0,        32'h80000000, 32'h00000004, 32'h08000000, 1'b0},
      '{4'd14, 32'h0,        32'h80000000, 32'h00000004, 32'hF8000000, 1'b0},
      '{4'd15, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0}
    };
    foreach (vecs[i]) begin
      alu_op = vecs[i].op; rs = vecs[i].a; rt = vecs[i].b; ext = vecs[i].e;
      #1;
      check($sformatf("alu_out op%0d #%0d", vecs[i].op, i), 64'(alu_out), 64'(vecs[i].res));
      check($sformatf("alu_ovf op%0d #%0d", vecs[i].op, i), 64'(alu_ovf), 64'(vecs[i].ovf));
    end
    alu_op = '0; ext = '0;
    step();

    // mult / multu
    md_go(3'd1, 32'hFFFFFFFF, 32'h00000002);
    wait_idle("mult_busy", 5);
    check("mult_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo_out), 64'hFFFFFFFE);
    md_go(3'd2, 32'hFFFFFFFF, 32'h00000002);
    wait_idle("multu_busy", 5);
    check("multu_hi", 64'(hi_out), 64'h00000001);
    check("multu_lo", 64'(lo_out), 64'hFFFFFFFE);

    // div, including MIN / -1
    md_go(3'd3, 32'hFFFFFFF9, 32'h00000002);
    wait_idle("div_busy", 10);
    check("div_lo", 64'(lo_out), 64'hFFFFFFFD);
    check("div_hi", 64'(hi_out), 64'hFFFFFFFF);
    md_go(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("divmin_busy", 10);
    check("divmin_lo", 64'(lo_out), 64'h80000000);
    check("divmin_hi", 64'(hi_out), 64'h00000000);
    md_go(3'd4, 32'h00000064, 32'h00000007);
    wait_idle("divu_busy", 10);
    check("divu_lo", 64'(lo_out), 64'h0000000E);
    check("divu_hi", 64'(hi_out), 64'h00000002);

    // mthi / mtlo, then divide by zero leaves HI/LO alone
    md_go(3'd5, 32'h12345678, 32'h0);
    check("mthi_busy", 64'(md_busy), 64'd0);
    check("mthi_hi", 64'(hi_out), 64'h12345678);
    md_go(3'd6, 32'h0BADF00D, 32'h0);
    check("mtlo_lo", 64'(lo_out), 64'h0BADF00D);
    md_go(3'd4, 32'h00000005, 32'h00000000);
    wait_idle("div0_busy", 10);
    check("div0_hi", 64'(hi_out), 64'h12345678);
    check("div0_lo", 64'(lo_out), 64'h0BADF00D);

    // start while busy is ignored
    md_go(3'd1, 32'h00000003, 32'h00000005);
    check("ign_busy1", 64'(md_busy), 64'd1);
    step();
    md_op = 3'd6; rs = 32'h000000AA; md_start = 1'b1;
    step();
    md_start = 1'b0; md_op = 3'd0; rs = 32'hDEADBEEF;
    wait_idle("ign_busy_rest", 3);
    check("ign_lo", 64'(lo_out), 64'h0000000F);
    check("ign_hi", 64'(hi_out), 64'h00000000);

    // reset in busy cycle 3 of a divide
    md_go(3'd3, 32'h00000064, 32'h00000007);
    step(); step();
    check("rstmid_busy3", 64'(md_busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_busy", 64'(md_busy), 64'd0);
    check("rstmid_hi", 64'(hi_out), 64'd0);
    check("rstmid_lo", 64'(lo_out), 64'd0);
    repeat (12) step();
    check("rstmid_late_hi", 64'(hi_out), 64'd0);
    check("rstmid_late_lo", 64'(lo_out), 64'd0);
    md_go(3'd1, 32'hFFFFFFFD, 32'hFFFFFFFB);
    wait_idle("post_rst_busy", 5);
    check("post_rst_hi", 64'(hi_out), 64'h00000000);
    check("post_rst_lo", 64'(lo_out), 64'h0000000F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
